// File: rtl/key_detect.sv
// Per-key fingertip pixel counter with per-frame thresholded publish.
// Optional debounce: define KEY_DETECT_DEBOUNCE_EN.
module key_detect #(
   parameter int NUM_KEYS  = 39,
   parameter int KEY_Y_MIN = 320,
   parameter int THRESH    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pix_valid,
   input  logic [31:0]         addr,
   input  logic                is_finger,
   input  logic                frame_end,
   output logic [NUM_KEYS:0]   key_down,
   output logic                key_valid
);

   typedef enum logic {SYNC, ACCUM} state_t;

   state_t            state_q;
   logic [7:0]        cnt_q [NUM_KEYS+1];
   logic [7:0]        cnt_d [NUM_KEYS+1];
   logic [NUM_KEYS:0] raw_d;
   logic [NUM_KEYS:0] key_down_q;
   logic [NUM_KEYS:0] key_down_d;
   logic              key_valid_q;
   logic [15:0]       pix_y;
   logic [11:0]       key_id;
   logic              hit;

   assign pix_y  = addr[31:16];
   assign key_id = addr[15:4];

   assign hit = pix_valid && is_finger
             && (int'({16'd0, pix_y}) > KEY_Y_MIN)
             && (int'({20'd0, key_id}) <= NUM_KEYS);

   // cnt_d already folds in this cycle's hit, so a hit on
   // the frame_end cycle is counted in the ending frame.
   always_comb begin
      for (int i = 0; i <= NUM_KEYS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (hit && key_id == 12'(i) && cnt_q[i] != 8'hFF)
            cnt_d[i] = cnt_q[i] + 8'd1;
         raw_d[i] = int'({24'd0, cnt_d[i]}) >= THRESH;
      end
   end

`ifdef KEY_DETECT_DEBOUNCE_EN
   logic [NUM_KEYS:0] prev_q;

   // Follow raw only when two consecutive publishes agree.
   assign key_down_d = (~(raw_d ^ prev_q) & raw_d)
                     | ((raw_d ^ prev_q) & key_down_q);
`else
   assign key_down_d = raw_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SYNC;
         key_down_q  <= '0;
         key_valid_q <= 1'b0;
         for (int i = 0; i <= NUM_KEYS; i++)
            cnt_q[i] <= 8'd0;
`ifdef KEY_DETECT_DEBOUNCE_EN
         prev_q      <= '0;
`endif
      end else begin
         key_valid_q <= 1'b0;
         unique case (state_q)
            SYNC: begin
               for (int i = 0; i <= NUM_KEYS; i++)
                  cnt_q[i] <= 8'd0;
               if (frame_end)
                  state_q <= ACCUM;
            end
            ACCUM: begin
               if (frame_end) begin
                  key_down_q  <= key_down_d;
                  key_valid_q <= 1'b1;
                  for (int i = 0; i <= NUM_KEYS; i++)
                     cnt_q[i] <= 8'd0;
`ifdef KEY_DETECT_DEBOUNCE_EN
                  prev_q      <= raw_d;
`endif
               end else begin
                  for (int i = 0; i <= NUM_KEYS; i++)
                     cnt_q[i] <= cnt_d[i];
               end
            end
         endcase
      end
   end

   assign key_down  = key_down_q;
   assign key_valid = key_valid_q;

endmodule

// File: tb/tb_key_detect.sv
// Randomized + directed bench for key_detect against a frame-level
// counting model; covers THRESH 16, 0 and 300 with three instances.
module tb_key_detect;

   localparam int N    = 39;
   localparam int YMIN = 320;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic [31:0]   addr = '0;
   logic          is_finger = 1'b0;
   logic          frame_end = 1'b0;
   logic [N:0]    kd0, kd1, kd2;
   logic          kv0, kv1, kv2;

   int tests = 0;
   int fails = 0;

   int         m_cnt [N+1];
   bit         m_accum;
   bit         m_valid;
   logic [N:0] m_down [3];
   logic [N:0] m_prev [3];

   always #5 clk = ~clk;

   key_detect #(.NUM_KEYS(N), .KEY_Y_MIN(YMIN), .THRESH(16)) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .addr(addr),
      .is_finger(is_finger), .frame_end(frame_end),
      .key_down(kd0), .key_valid(kv0));

   key_detect #(.NUM_KEYS(N), .KEY_Y_MIN(YMIN), .THRESH(0)) dut_t0 (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .addr(addr),
      .is_finger(is_finger), .frame_end(frame_end),
      .key_down(kd1), .key_valid(kv1));

   key_detect #(.NUM_KEYS(N), .KEY_Y_MIN(YMIN), .THRESH(300)) dut_tbig (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .addr(addr),
      .is_finger(is_finger), .frame_end(frame_end),
      .key_down(kd2), .key_valid(kv2));

   function automatic int thr(input int j);
      case (j)
         0: return 16;
         1: return 0;
         default: return 300;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_accum = 1'b0;
      m_valid = 1'b0;
      for (int i = 0; i <= N; i++) m_cnt[i] = 0;
      for (int j = 0; j < 3; j++) begin
         m_down[j] = '0;
         m_prev[j] = '0;
      end
   endtask

   // Frame-level behaviour: SYNC frame is discarded, every later
   // frame_end publishes count>=threshold and restarts counting.
   task automatic model_step(input bit pv, input logic [31:0] a,
                             input bit fin, input bit fe);
      int         k;
      bit         hit;
      logic [N:0] raw;
      k   = int'(a[15:4]);
      hit = pv && fin && (int'(a[31:16]) > YMIN) && (k <= N);
      m_valid = 1'b0;
      if (!m_accum) begin
         for (int i = 0; i <= N; i++) m_cnt[i] = 0;
         if (fe) m_accum = 1'b1;
      end else begin
         if (hit) m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
         if (fe) begin
            m_valid = 1'b1;
            for (int j = 0; j < 3; j++) begin
               for (int i = 0; i <= N; i++)
                  raw[i] = (m_cnt[i] >= thr(j));
`ifdef KEY_DETECT_DEBOUNCE_EN
               for (int i = 0; i <= N; i++)
                  if (raw[i] == m_prev[j][i]) m_down[j][i] = raw[i];
               m_prev[j] = raw;
`else
               m_down[j] = raw;
`endif
            end
            for (int i = 0; i <= N; i++) m_cnt[i] = 0;
         end
      end
   endtask

   task automatic chk_outs();
      chk("key_down", 64'(kd0), 64'(m_down[0]));
      chk("key_valid", 64'(kv0), 64'(m_valid));
      chk("key_down_t0", 64'(kd1), 64'(m_down[1]));
      chk("key_valid_t0", 64'(kv1), 64'(m_valid));
      chk("key_down_t300", 64'(kd2), 64'(m_down[2]));
      chk("key_valid_t300", 64'(kv2), 64'(m_valid));
   endtask

   task automatic chk_cnts();
      for (int i = 0; i <= N; i++)
         chk($sformatf("cnt[%0d]", i), 64'(dut.cnt_q[i]), 64'(m_cnt[i]));
   endtask

   task automatic cycle(input bit pv, input logic [31:0] a,
                        input bit fin, input bit fe);
      pix_valid = pv;
      addr      = a;
      is_finger = fin;
      frame_end = fe;
      @(posedge clk);
      #1;
      model_step(pv, a, fin, fe);
      chk_outs();
   endtask

   function automatic logic [31:0] px(input int y, input int key);
      return {16'(y), 16'(key * 16 + int'($urandom_range(0, 15)))};
   endfunction

   task automatic hits(input int key, input int n);
      repeat (n) cycle(1'b1, px(400, key), 1'b1, 1'b0);
   endtask

   task automatic fend();
      cycle(1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      pix_valid = 1'b0;
      is_finger = 1'b0;
      frame_end = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      chk_outs();
      chk_cnts();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      do_reset();

      // Frame in SYNC is discarded, no publish.
      hits(3, 20);
      chk_cnts();
      fend();
      chk("sync_valid", 64'(kv0), 64'd0);
      chk("sync_down", 64'(kd0), 64'd0);

      // First real frame.
      hits(3, 16);
      hits(5, 15);
      fend();
`ifndef KEY_DETECT_DEBOUNCE_EN
      chk("frame1_down", 64'(kd0), 64'h8);
`endif
      chk("frame1_valid", 64'(kv0), 64'd1);
      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      chk("valid_one_cycle", 64'(kv0), 64'd0);

      // Ignored pixels: y boundary, key out of range, no finger.
      for (int c = 0; c < 300; c++) begin
         case (c % 5)
            0: cycle(1'b1, px(320, 4), 1'b1, 1'b0);
            1: cycle(1'b1, px(400, 40), 1'b1, 1'b0);
            2: cycle(1'b1, px(400, 6), 1'b0, 1'b0);
            3: cycle(1'b0, px(400, 6), 1'b1, 1'b0);
            default: cycle(1'b1, px(400, 4095), 1'b1, 1'b0);
         endcase
      end
      chk_cnts();
      fend();
      chk("ignored_down", 64'(kd0), 64'd0);
      chk_cnts();

      // Saturation on key 0.
      hits(0, 300);
      chk("sat_cnt0", 64'(dut.cnt_q[0]), 64'd255);
      fend();
`ifndef KEY_DETECT_DEBOUNCE_EN
      chk("sat_down0", 64'(kd0[0]), 64'd1);
`endif

      // 16th hit lands on the frame_end cycle.
      hits(7, 15);
      cycle(1'b1, px(400, 7), 1'b1, 1'b1);
`ifndef KEY_DETECT_DEBOUNCE_EN
      chk("edge_hit_down7", 64'(kd0[7]), 64'd1);
`endif
      chk("edge_hit_cnt7", 64'(dut.cnt_q[7]), 64'd0);

      // Back-to-back frame_end: second publish sees one edge only.
      hits(1, 20);
      fend();
      cycle(1'b1, px(400, 1), 1'b1, 1'b1);
      chk("b2b_valid", 64'(kv0), 64'd1);
`ifndef KEY_DETECT_DEBOUNCE_EN
      chk("b2b_down1", 64'(kd0[1]), 64'd0);
`endif

      // Randomized frames with hits around the y boundary.
      for (int f = 0; f < 30; f++) begin
         int len;
         len = (f % 7 == 6) ? 1 : int'($urandom_range(10, 70));
         for (int c = 0; c < len; c++) begin
            int k;
            int y;
            k = ($urandom % 4 == 0) ? int'($urandom_range(0, 45))
                                    : int'($urandom_range(0, 3));
            y = int'($urandom_range(315, 330));
            cycle(($urandom % 4) != 0, px(y, k), ($urandom % 3) != 0,
                  c == len - 1);
         end
         chk_cnts();
      end

      // Mid-frame reset clears key_down asynchronously.
      hits(2, 20);
      fend();
      hits(2, 20);
      fend();
      hits(2, 5);
      do_reset();
      chk("mid_rst_down", 64'(kd0), 64'd0);
      hits(2, 20);
      fend();
      chk("post_rst_sync", 64'(kv0), 64'd0);

`ifdef KEY_DETECT_DEBOUNCE_EN
      hits(2, 20);
      fend();
      chk("deb_A", 64'(kd0[2]), 64'd0);
      hits(2, 3);
      fend();
      chk("deb_B", 64'(kd0[2]), 64'd0);
      hits(2, 20);
      fend();
      chk("deb_C", 64'(kd0[2]), 64'd0);
      hits(2, 20);
      fend();
      chk("deb_D", 64'(kd0[2]), 64'd1);
      hits(2, 4);
      do_reset();
      chk("deb_rst", 64'(kd0), 64'd0);
`else
      hits(2, 16);
      fend();
      chk("plain_down2", 64'(kd0), 64'h4);
`endif

      cycle(1'b0, 32'd0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
